oldland_tlb_walker: RTL and testbench
=====================================

Name: oldland_tlb_walker

Overview:
Hardware TLB refill engine; the responder to the TLB's miss output. On a miss it walks a two-level page table in memory through a read-only bus master port and refills the TLB. It drives the TLB maintenance interface (load_data/load_virt/load_phys) in the word order the TLB expects. Sits beside the TLB in the MMU; faults are reported to the exception unit.

Parameters:
timeout_cycles, 255, cycles to wait for mem_ack before a bus-timeout fault (1..255, 8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
miss  in  1  TLB miss, level, sampled only in IDLE
miss_virt  in  20  faulting VA[31:12], captured with miss
ptbr  in  32  page table base; bits [31:12] used
abort  in  1  cancel current walk (pipeline flush)
mem_req  out  1  read request, held until mem_ack
mem_addr  out  32  word-aligned read address
mem_ack  in  1  one-cycle read completion
mem_data  in  32  read data, valid with mem_ack
load_data  out  32  TLB load word
load_virt  out  1  one-cycle strobe: load_data = virtual word
load_phys  out  1  one-cycle strobe: load_data = physical word
starting_miss  out  1  one-cycle pulse on walk start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after a successful refill
fault  out  1  one-cycle fault pulse
fault_code  out  2  01 PDE absent, 10 PTE absent, 11 bus timeout; held until next walk

Behaviour:
- Reset (rst low, async): state IDLE; mem_req, load_virt, load_phys, starting_miss, busy, done, fault = 0; fault_code = 00; mem_addr, load_data = 0; timeout counter = 0.
- Entry format (PDE and PTE): [31:12] frame, bit 4 present, [1:0] access, other bits ignored.
- IDLE: miss=1 -> capture va=miss_virt and ptbr[31:12]; pulse starting_miss; go L1_REQ.
- L1_REQ: mem_req=1, mem_addr={ptbr[31:12], va[31:22], 2'b00}; go L1_WAIT next cycle. mem_req stays high until mem_ack.
- L1_WAIT: on mem_ack, capture PDE. If bit 4 = 0 -> FAULT(01), else L2_REQ.
- L2_REQ/L2_WAIT: mem_addr={pde[31:12], va[21:12], 2'b00}; on mem_ack, PTE bit 4 = 0 -> FAULT(10), else LOAD_V.
- LOAD_V: load_virt=1, load_data={va, 10'b0, pte[1:0]}.
- LOAD_P (next cycle): load_phys=1, load_data={pte[31:12], 12'b0}.
- DONE (next cycle): done=1; go IDLE. Minimum latency from miss to done with zero-wait memory (ack in the cycle after req) is 7 cycles.
- FAULT: fault=1 and fault_code set for one cycle; go IDLE; no TLB load occurs.
- Timeout: the counter clears when entering each *_REQ and increments each cycle mem_req is high without mem_ack. Reaching timeout_cycles -> drop mem_req, FAULT(11).
- abort in L1_REQ/L1_WAIT/L2_REQ/L2_WAIT: set pending-abort flag; keep mem_req until mem_ack or timeout, then go IDLE with no load, no done, no fault.
- abort in LOAD_V: go IDLE; load_phys is not issued. The TLB's staged virt word is harmless.
- abort in LOAD_P/DONE/FAULT: ignored; that state completes.
- miss while busy: ignored. Back-to-back walks are allowed: a miss still high in IDLE the cycle after DONE starts a new walk.
- mem_ack outside the WAIT states is ignored.
- mem_addr holds its value while mem_req is high.
- Async reset mid-walk drops mem_req immediately. The external bus must tolerate a dropped request.

Decomposition:
- Shared package oldland_mmu_pkg holds the walker state enum; PTE field constants (PTE_PRESENT_BIT=4, PTE_ACCESS_MSB=1, PTE_FRAME range); fault code constants FAULT_NONE/PDE/PTE/TIMEOUT.
- One sub-module: oldland_walk_timer (loadable 8-bit counter with expired flag).

Test Plan:
- Happy path: ptbr=0x0010_0000, miss_virt=0x12345, PDE@0x0010_0120=0x0020_0011, PTE@0x0020_0D14=0xABCD_E013 -> load_virt with load_data=0x1234_5003, next cycle load_phys with 0xABCD_E000, then done.
- PDE absent: PDE=0x0020_0000 -> fault with fault_code=01 after L1 ack; no load strobes; exactly one mem_req transaction.
- PTE absent: valid PDE, PTE=0xABCD_E003 -> fault_code=10; no load_virt/load_phys.
- Timeout: timeout_cycles=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then fault with fault_code=11, busy low the next cycle.
- Abort in L2_WAIT with ack delayed 3 cycles -> mem_req held until ack; no load, no done, no fault; IDLE afterwards.
- Reset mid L1_WAIT (rst low asynchronously, off clock edge) -> mem_req and busy fall immediately; a new miss after release starts a walk with starting_miss pulse.

Source files
------------

// File: rtl/oldland_mmu_pkg.sv
// Shared MMU definitions: walker states, page-table entry fields and fault codes.
package oldland_mmu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_L1_REQ  = 4'd1,
    ST_L1_WAIT = 4'd2,
    ST_L2_REQ  = 4'd3,
    ST_L2_WAIT = 4'd4,
    ST_LOAD_V  = 4'd5,
    ST_LOAD_P  = 4'd6,
    ST_DONE    = 4'd7,
    ST_FAULT   = 4'd8
  } walker_state_e;

  localparam int unsigned PTE_PRESENT_BIT = 4;
  localparam int unsigned PTE_ACCESS_MSB  = 1;
  localparam int unsigned PTE_FRAME_MSB   = 31;
  localparam int unsigned PTE_FRAME_LSB   = 12;

  localparam int unsigned TMR_W = 8;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_PDE     = 2'b01;
  localparam logic [1:0] FAULT_PTE     = 2'b10;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b11;

endpackage

// File: rtl/oldland_walk_timer.sv
// Bus-timeout counter: cleared at each request, counts stalled request cycles.
module oldland_walk_timer
  import oldland_mmu_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired_c
);

  localparam int unsigned CNT_W1 = TMR_W + 1;

  logic [TMR_W-1:0]  r_cnt;
  logic [CNT_W1-1:0] w_next;

  assign w_next      = {1'b0, r_cnt} + CNT_W1'(1);
  // Expires on the stalled cycle whose increment would reach the limit.
  assign o_expired_c = i_inc && (w_next >= CNT_W1'(LIMIT));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_next[TMR_W]) begin
      r_cnt <= w_next[TMR_W-1:0];
    end
  end

endmodule

// File: rtl/oldland_tlb_walker.sv
// TLB refill engine: walks a two-level page table on a miss and loads the TLB
// with the virtual word followed by the physical word.
module oldland_tlb_walker
  import oldland_mmu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_miss,
  input  logic [19:0] i_miss_virt,
  input  logic [31:0] i_ptbr,
  input  logic        i_abort,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic [31:0] o_load_data,
  output logic        o_load_virt,
  output logic        o_load_phys,
  output logic        o_starting_miss,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_fault,
  output logic [1:0]  o_fault_code
);

  walker_state_e r_state;
  logic [19:0]   r_va;
  logic [19:0]   r_pte_frame;
  logic          r_abort_pend;
  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_load_data;
  logic          r_load_virt;
  logic          r_load_phys;
  logic          r_starting_miss;
  logic          r_busy;
  logic          r_done;
  logic          r_fault;
  logic [1:0]    r_fault_code;

  logic w_abort;
  logic w_present;
  logic w_is_wait;
  logic w_expired;
  logic w_tmr_clr;
  logic w_tmr_inc;
  logic w_unused_bits;

  assign w_abort   = r_abort_pend | i_abort;
  assign w_present = i_mem_data[PTE_PRESENT_BIT];
  assign w_is_wait = (r_state == ST_L1_WAIT) || (r_state == ST_L2_WAIT);
  assign w_tmr_inc = r_mem_req && !i_mem_ack;
  // Timer restarts on entry to either request state.
  assign w_tmr_clr = ((r_state == ST_IDLE) && i_miss) ||
                     ((r_state == ST_L1_WAIT) && i_mem_ack && !w_abort && w_present);
  assign w_unused_bits = ^{i_ptbr[11:0], i_mem_data[11:5], i_mem_data[3:2]};

  oldland_walk_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (w_tmr_clr),
    .i_inc       (w_tmr_inc),
    .o_expired_c (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state         <= ST_IDLE;
      r_va            <= '0;
      r_pte_frame     <= '0;
      r_abort_pend    <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
      r_load_data     <= '0;
      r_load_virt     <= 1'b0;
      r_load_phys     <= 1'b0;
      r_starting_miss <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_fault         <= 1'b0;
      r_fault_code    <= FAULT_NONE;
    end else begin
      r_starting_miss <= 1'b0;
      r_load_virt     <= 1'b0;
      r_load_phys     <= 1'b0;
      r_done          <= 1'b0;
      r_fault         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_miss) begin
            r_va            <= i_miss_virt;
            r_mem_req       <= 1'b1;
            r_mem_addr      <= {i_ptbr[31:12], i_miss_virt[19:10], 2'b00};
            r_starting_miss <= 1'b1;
            r_busy          <= 1'b1;
            r_fault_code    <= FAULT_NONE;
            r_abort_pend    <= 1'b0;
            r_state         <= ST_L1_REQ;
          end
        end
        ST_L1_REQ, ST_L1_WAIT, ST_L2_REQ, ST_L2_WAIT: begin
          if (i_abort) r_abort_pend <= 1'b1;
          if (w_is_wait && i_mem_ack) begin
            if (w_abort) begin
              r_mem_req <= 1'b0;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end else if (!w_present) begin
              r_mem_req    <= 1'b0;
              r_fault      <= 1'b1;
              r_fault_code <= (r_state == ST_L1_WAIT) ? FAULT_PDE : FAULT_PTE;
              r_state      <= ST_FAULT;
            end else if (r_state == ST_L1_WAIT) begin
              r_mem_addr <= {i_mem_data[PTE_FRAME_MSB:PTE_FRAME_LSB], r_va[9:0], 2'b00};
              r_state    <= ST_L2_REQ;
            end else begin
              r_mem_req   <= 1'b0;
              r_pte_frame <= i_mem_data[PTE_FRAME_MSB:PTE_FRAME_LSB];
              r_load_virt <= 1'b1;
              r_load_data <= {r_va, 10'b0, i_mem_data[PTE_ACCESS_MSB:0]};
              r_state     <= ST_LOAD_V;
            end
          end else if (w_expired) begin
            // A pending abort swallows the timeout fault.
            r_mem_req <= 1'b0;
            if (w_abort) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_fault      <= 1'b1;
              r_fault_code <= FAULT_TIMEOUT;
              r_state      <= ST_FAULT;
            end
          end else if (r_state == ST_L1_REQ) begin
            r_state <= ST_L1_WAIT;
          end else if (r_state == ST_L2_REQ) begin
            r_state <= ST_L2_WAIT;
          end
        end
        ST_LOAD_V: begin
          if (i_abort) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_load_phys <= 1'b1;
            r_load_data <= {r_pte_frame, 12'b0};
            r_state     <= ST_LOAD_P;
          end
        end
        ST_LOAD_P: begin
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_DONE, ST_FAULT: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_mem_req <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_mem_req       = r_mem_req;
  assign o_mem_addr      = r_mem_addr;
  assign o_load_data     = r_load_data;
  assign o_load_virt     = r_load_virt;
  assign o_load_phys     = r_load_phys;
  assign o_starting_miss = r_starting_miss;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_fault         = r_fault;
  assign o_fault_code    = r_fault_code;

endmodule

// File: tb/tb_oldland_tlb_walker.sv
// Self-checking bench for oldland_tlb_walker: page-table memory model plus an
// event scoreboard for TLB loads, done and fault pulses.
module tb_oldland_tlb_walker;
  import oldland_mmu_pkg::*;

  localparam int EV_LV = 0, EV_LP = 1, EV_DONE = 2, EV_FAULT = 3;

  typedef struct {
    logic [19:0] va;
    logic [31:0] ptbr;
    logic [31:0] pde;
    logic [31:0] pte;
    logic [1:0]  code;
    logic [31:0] virt;
    logic [31:0] phys;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } ev_t;

  logic        clk, rst, miss, abort, mem_ack;
  logic [19:0] miss_virt;
  logic [31:0] ptbr, mem_data, mem_addr, load_data;
  logic        mem_req, load_virt, load_phys, starting_miss, busy, done, fault;
  logic [1:0]  fault_code;

  oldland_tlb_walker #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_miss(miss), .i_miss_virt(miss_virt),
    .i_ptbr(ptbr), .i_abort(abort), .o_mem_req(mem_req), .o_mem_addr(mem_addr),
    .i_mem_ack(mem_ack), .i_mem_data(mem_data), .o_load_data(load_data),
    .o_load_virt(load_virt), .o_load_phys(load_phys),
    .o_starting_miss(starting_miss), .o_busy(busy), .o_done(done),
    .o_fault(fault), .o_fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Page-table memory: two programmed entries, everything else reads as absent.
  logic [31:0] m_pde_addr, m_pde_val, m_pte_addr, m_pte_val;
  bit          ack_en;
  int          ack_delay;
  int          wait_cnt;
  int          n_txn = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a == m_pde_addr) return m_pde_val;
    if (a == m_pte_addr) return m_pte_val;
    return 32'hDEAD_0000;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_ack  <= 1'b0;
      mem_data <= '0;
      wait_cnt <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack && ack_en) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  <= 1'b1;
          mem_data <= mem_read(mem_addr);
          wait_cnt <= 0;
          n_txn    <= n_txn + 1;
        end else begin
          wait_cnt <= wait_cnt + 1;
        end
      end else if (!mem_req) begin
        wait_cnt <= 0;
      end
    end
  end

  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;
  bit   seen_done, seen_fault;
  ev_t  exp_q[$];
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_ev(input int kind, input logic [31:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d data 0x%08h expected none at %0t", kind, data, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_data", data, e.data);
    end
  endtask

  task automatic mon();
    if (load_virt) begin check_ev(EV_LV, load_data); strobe_cnt++; end
    if (load_phys) begin check_ev(EV_LP, load_data); strobe_cnt++; end
    if (done)      begin check_ev(EV_DONE, 32'h0); seen_done = 1'b1; end
    if (fault)     begin check_ev(EV_FAULT, {30'h0, fault_code}); seen_fault = 1'b1; end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
  endtask

  task automatic push_vec(input vec_t v);
    ev_t e;
    if (v.code == FAULT_NONE) begin
      e.kind = EV_LV;   e.data = v.virt; exp_q.push_back(e);
      e.kind = EV_LP;   e.data = v.phys; exp_q.push_back(e);
      e.kind = EV_DONE; e.data = 32'h0;  exp_q.push_back(e);
    end else begin
      e.kind = EV_FAULT; e.data = {30'h0, v.code}; exp_q.push_back(e);
    end
  endtask

  task automatic load_mem(input vec_t v);
    m_pde_addr = {v.ptbr[31:12], v.va[19:10], 2'b00};
    m_pde_val  = v.pde;
    m_pte_addr = {v.pde[31:12], v.va[9:0], 2'b00};
    m_pte_val  = v.pte;
  endtask

  task automatic run_vec(input vec_t v);
    int lat, base;
    load_mem(v);
    ack_en = 1'b1; ack_delay = 0;
    base = n_txn;
    push_vec(v);
    seen_done = 1'b0; seen_fault = 1'b0;
    miss = 1'b1; miss_virt = v.va; ptbr = v.ptbr;
    step();
    lat = 1;
    check("starting_miss", 32'(starting_miss), 32'd1);
    check("busy_walking", 32'(busy), 32'd1);
    miss = 1'b0;
    while (!seen_done && !seen_fault && lat < 30) begin step(); lat++; end
    check("walk_finished", 32'(seen_done | seen_fault), 32'd1);
    if (v.code == FAULT_NONE) check("done_latency", 32'(lat), 32'd7);
    else check("fault_latency", 32'(lat), (v.code == FAULT_PDE) ? 32'd3 : 32'd5);
    step();
    check("busy_after", 32'(busy), 32'd0);
    check("fault_code_held", 32'(fault_code), 32'(v.code));
    check("txn_count", 32'(n_txn - base), (v.code == FAULT_PDE) ? 32'd1 : 32'd2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n, base, req_cycles, s0;
    bit found;
    ev_t e;

    vecs[0] = '{20'h12345, 32'h0010_0000, 32'h0020_0011, 32'hABCD_E013, 2'b00, 32'h1234_5003, 32'hABCD_E000};
    vecs[1] = '{20'h12345, 32'h0010_0000, 32'h0020_0000, 32'hABCD_E013, 2'b01, 32'h0, 32'h0};
    vecs[2] = '{20'h12345, 32'h0010_0000, 32'h0020_0011, 32'hABCD_E003, 2'b10, 32'h0, 32'h0};
    vecs[3] = '{20'hFFFFF, 32'hFFFF_F000, 32'h1234_5FFF, 32'h0000_1012, 2'b00, 32'hFFFF_F002, 32'h0000_1000};
    vecs[4] = '{20'h00000, 32'h0000_0000, 32'h0000_1010, 32'h0000_0011, 2'b00, 32'h0000_0001, 32'h0000_0000};

    rst = 1'b0; miss = 1'b0; abort = 1'b0; miss_virt = '0; ptbr = '0;
    ack_en = 1'b1; ack_delay = 0;
    load_mem(vecs[0]);
    repeat (3) step();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_fault_code", 32'(fault_code), 32'd0);
    check("rst_strobes", 32'({load_virt, load_phys, starting_miss, done, fault}), 32'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Back-to-back: miss held high across DONE restarts a walk after one IDLE cycle.
    load_mem(vecs[0]);
    push_vec(vecs[0]); push_vec(vecs[0]);
    seen_done = 1'b0;
    miss = 1'b1; miss_virt = vecs[0].va; ptbr = vecs[0].ptbr;
    n = 0;
    while (!seen_done && n < 30) begin step(); n++; end
    check("b2b_first_done", 32'(seen_done), 32'd1);
    step();
    check("b2b_idle_gap", 32'({busy, starting_miss}), 32'd0);
    step();
    check("b2b_restart", 32'(starting_miss), 32'd1);
    miss = 1'b0;
    seen_done = 1'b0; n = 0;
    while (!seen_done && n < 30) begin step(); n++; end
    check("b2b_second_done", 32'(seen_done), 32'd1);
    step();
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // Timeout: no ack ever, limit 4.
    ack_en = 1'b0;
    e.kind = EV_FAULT; e.data = 32'd3; exp_q.push_back(e);
    seen_fault = 1'b0;
    miss = 1'b1;
    step();
    miss = 1'b0;
    req_cycles = mem_req ? 1 : 0;
    n = 0;
    while (!seen_fault && n < 30) begin step(); n++; if (mem_req) req_cycles++; end
    check("tmo_fault_seen", 32'(seen_fault), 32'd1);
    check("tmo_req_cycles", 32'(req_cycles), 32'd4);
    step();
    check("tmo_busy_low", 32'(busy), 32'd0);
    check("tmo_fault_code", 32'(fault_code), 32'd3);
    check("tmo_queue_empty", 32'(exp_q.size()), 32'd0);
    ack_en = 1'b1;

    // Abort in L2_WAIT with ack 3 cycles after request.
    load_mem(vecs[0]);
    ack_delay = 2;
    base = n_txn; s0 = strobe_cnt;
    seen_done = 1'b0; seen_fault = 1'b0;
    miss = 1'b1;
    step();
    miss = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 30) begin step(); n++; found = (mem_req && mem_addr == m_pte_addr); end
    check("abort_reached_l2", 32'(found), 32'd1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_req_held", 32'(mem_req), 32'd1);
    n = 0;
    while (busy && n < 30) begin step(); n++; end
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_req_dropped", 32'(mem_req), 32'd0);
    check("abort_no_done_fault", 32'({seen_done, seen_fault}), 32'd0);
    check("abort_no_loads", 32'(strobe_cnt - s0), 32'd0);
    check("abort_txn_count", 32'(n_txn - base), 32'd2);
    ack_delay = 0;

    // Asynchronous reset while waiting for the PDE.
    ack_en = 1'b0;
    miss = 1'b1;
    step();
    miss = 1'b0;
    step();
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", 32'(mem_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    step();
    rst = 1'b1;
    step();
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1);
  end

endmodule
